// File: rtl/hbridge_pkg.sv
// Shared types for the H-bridge gate sequencer: channel FSM states, the decoded
// per-channel command, and small decode helpers.
package hbridge_pkg;

  typedef enum logic [2:0] {
    StCoast = 3'd0,
    StFwd   = 3'd1,
    StRev   = 3'd2,
    StBrake = 3'd3,
    StDead  = 3'd4,
    StFault = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CmdCst = 3'd0,
    CmdFwd = 3'd1,
    CmdRev = 3'd2,
    CmdBrk = 3'd3,
    CmdFlt = 3'd4
  } cmd_e;

  // Highest priority first: fault, brake, disable, direction.
  function automatic cmd_e decode_cmd(input logic fault, input logic brake, input logic en,
                                      input logic dir);
    cmd_e cmd;
    if (fault)      cmd = CmdFlt;
    else if (brake) cmd = CmdBrk;
    else if (!en)   cmd = CmdCst;
    else if (!dir)  cmd = CmdFwd;
    else            cmd = CmdRev;
    return cmd;
  endfunction

  function automatic state_e drive_state(input cmd_e cmd);
    state_e st;
    case (cmd)
      CmdFwd:  st = StFwd;
      CmdRev:  st = StRev;
      CmdBrk:  st = StBrake;
      default: st = StCoast;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/hbridge_channel_fsm.sv
// One H-bridge channel: command decode, drive-state FSM with dead-time coast
// between opposing drive states, and registered gate outputs.
module hbridge_channel_fsm
  import hbridge_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 2000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  input  logic en_i,
  input  logic dir_i,
  input  logic brake_i,
  input  logic fault_i,
  output logic hi_o,
  output logic lo_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] DeadLoad = CNT_W'(DEAD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hi_q, hi_d, lo_q, lo_d, busy_q, busy_d;
  cmd_e             cmd;
  state_e           target;

  assign cmd    = decode_cmd(fault_i, brake_i, en_i, dir_i);
  assign target = drive_state(cmd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cmd == CmdFlt) begin
      state_d = StFault;
    end else if (state_q == StFault) begin
      state_d = StCoast;
    end else if (cmd == CmdCst) begin
      state_d = StCoast;
    end else begin
      case (state_q)
        StCoast: state_d = target;
        StFwd, StRev, StBrake: begin
          if (target != state_q) begin
            state_d = StDead;
            cnt_d   = DeadLoad;
          end
        end
        // Exit follows whatever is commanded when the count expires.
        StDead: begin
          if (cnt_q == '0) state_d = target;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = StCoast;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as it.
  always_comb begin
    hi_d   = 1'b0;
    lo_d   = 1'b0;
    busy_d = (state_d == StDead);
    case (state_d)
      StFwd:   hi_d = pwm_i;
      StRev:   lo_d = pwm_i;
      StBrake: begin
        hi_d = 1'b1;
        lo_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StCoast;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/hbridge_gate_sequencer.sv
// Two-channel H-bridge gate sequencer: FAULT_N synchronizer, shared fault latch,
// and the two channel FSMs mapped onto IN1..IN4.
module hbridge_gate_sequencer #(
  parameter int unsigned DEAD_CYCLES = 2000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic PWM_A,
  input  logic EN_A,
  input  logic DIR_A,
  input  logic BRAKE_A,
  input  logic PWM_B,
  input  logic EN_B,
  input  logic DIR_B,
  input  logic BRAKE_B,
  input  logic FAULT_N,
  input  logic FAULT_CLR,
  output logic IN1,
  output logic IN2,
  output logic IN3,
  output logic IN4,
  output logic BUSY_A,
  output logic BUSY_B,
  output logic FAULT
);

  logic fs1_q, fs2_q;
  logic fault_q, fault_d;

  // A still-active fault pin beats a simultaneous clear.
  assign fault_d = !fs2_q || (fault_q && !FAULT_CLR);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      fs1_q   <= 1'b1;
      fs2_q   <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      fs1_q   <= FAULT_N;
      fs2_q   <= fs1_q;
      fault_q <= fault_d;
    end
  end

  assign FAULT = fault_q;

  hbridge_channel_fsm #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_a (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .pwm_i  (PWM_A),
    .en_i   (EN_A),
    .dir_i  (DIR_A),
    .brake_i(BRAKE_A),
    .fault_i(fault_q),
    .hi_o   (IN1),
    .lo_o   (IN2),
    .busy_o (BUSY_A)
  );

  hbridge_channel_fsm #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_b (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .pwm_i  (PWM_B),
    .en_i   (EN_B),
    .dir_i  (DIR_B),
    .brake_i(BRAKE_B),
    .fault_i(fault_q),
    .hi_o   (IN3),
    .lo_o   (IN4),
    .busy_o (BUSY_B)
  );

endmodule

// File: tb/tb_hbridge_gate_sequencer.sv
// Directed, table-driven bench for hbridge_gate_sequencer with DEAD_CYCLES=4.
module tb_hbridge_gate_sequencer;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic PWM_A = 1'b0, EN_A = 1'b0, DIR_A = 1'b0, BRAKE_A = 1'b0;
  logic PWM_B = 1'b0, EN_B = 1'b0, DIR_B = 1'b0, BRAKE_B = 1'b0;
  logic FAULT_N = 1'b1, FAULT_CLR = 1'b0;
  logic IN1, IN2, IN3, IN4, BUSY_A, BUSY_B, FAULT;

  hbridge_gate_sequencer #(
    .DEAD_CYCLES(4),
    .CNT_W      (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PWM_A    (PWM_A),
    .EN_A     (EN_A),
    .DIR_A    (DIR_A),
    .BRAKE_A  (BRAKE_A),
    .PWM_B    (PWM_B),
    .EN_B     (EN_B),
    .DIR_B    (DIR_B),
    .BRAKE_B  (BRAKE_B),
    .FAULT_N  (FAULT_N),
    .FAULT_CLR(FAULT_CLR),
    .IN1      (IN1),
    .IN2      (IN2),
    .IN3      (IN3),
    .IN4      (IN4),
    .BUSY_A   (BUSY_A),
    .BUSY_B   (BUSY_B),
    .FAULT    (FAULT)
  );

  always #5 PCLK = ~PCLK;

  // in:  {pwm_a,en_a,dir_a,brk_a, pwm_b,en_b,dir_b,brk_b, fault_n, fault_clr}
  // exp: {in1,in2,in3,in4, busy_a,busy_b, fault}
  typedef struct {
    string      name;
    logic [9:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  logic [6:0] obs;

  assign obs = {IN1, IN2, IN3, IN4, BUSY_A, BUSY_B, FAULT};

  task automatic add(input string n, input logic [9:0] i, input logic [6:0] e);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [9:0] i);
    {PWM_A, EN_A, DIR_A, BRAKE_A, PWM_B, EN_B, DIR_B, BRAKE_B, FAULT_N, FAULT_CLR} = i;
  endtask

  task automatic check(input string n, input logic [6:0] e);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, obs, e);
    end
  endtask

  initial begin
    // 1: coast -> fwd, no dead time
    add("fwd_pwm1",   10'b1100_0000_10, 7'b1000_00_0);
    add("fwd_pwm0",   10'b0100_0000_10, 7'b0000_00_0);
    add("fwd_pwm1b",  10'b1100_0000_10, 7'b1000_00_0);
    // 2: fwd -> rev through 4 dead cycles
    add("rev_dead1",  10'b1110_0000_10, 7'b0000_10_0);
    add("rev_dead2",  10'b1110_0000_10, 7'b0000_10_0);
    add("rev_dead3",  10'b1110_0000_10, 7'b0000_10_0);
    add("rev_dead4",  10'b1110_0000_10, 7'b0000_10_0);
    add("rev_pwm1",   10'b1110_0000_10, 7'b0100_00_0);
    add("rev_pwm0",   10'b0110_0000_10, 7'b0000_00_0);
    add("rev_pwm1b",  10'b1110_0000_10, 7'b0100_00_0);
    // 3: coast, fwd, brake through dead, then disable
    add("coast",      10'b0000_0000_10, 7'b0000_00_0);
    add("fwd_again",  10'b1100_0000_10, 7'b1000_00_0);
    add("brk_dead1",  10'b1101_0000_10, 7'b0000_10_0);
    add("brk_dead2",  10'b1101_0000_10, 7'b0000_10_0);
    add("brk_dead3",  10'b1101_0000_10, 7'b0000_10_0);
    add("brk_dead4",  10'b1101_0000_10, 7'b0000_10_0);
    add("brake_on",   10'b1101_0000_10, 7'b1100_00_0);
    add("brake_hold", 10'b0101_0000_10, 7'b1100_00_0);
    add("brake_off",  10'b0000_0000_10, 7'b0000_00_0);
    // 4: direction bounces back mid-dead; count is not restarted
    add("fwd_3",      10'b1100_0000_10, 7'b1000_00_0);
    add("bnc_dead1",  10'b1110_0000_10, 7'b0000_10_0);
    add("bnc_dead2",  10'b1100_0000_10, 7'b0000_10_0);
    add("bnc_dead3",  10'b1100_0000_10, 7'b0000_10_0);
    add("bnc_dead4",  10'b1100_0000_10, 7'b0000_10_0);
    add("bnc_fwd",    10'b1100_0000_10, 7'b1000_00_0);
    // 5: both channels driving, fault, blocked clear, real clear
    add("both_drive", 10'b1100_1110_10, 7'b1001_00_0);
    add("flt_sync1",  10'b1100_1110_00, 7'b1001_00_0);
    add("flt_sync2",  10'b1100_1110_00, 7'b1001_00_0);
    add("flt_latch",  10'b1100_1110_00, 7'b1001_00_1);
    add("flt_outs0",  10'b1100_1110_00, 7'b0000_00_1);
    add("flt_clr_ign",10'b1100_1110_01, 7'b0000_00_1);
    add("flt_rel1",   10'b1100_1110_10, 7'b0000_00_1);
    add("flt_rel2",   10'b1100_1110_10, 7'b0000_00_1);
    add("flt_clr",    10'b1100_1110_11, 7'b0000_00_0);
    add("flt_coast",  10'b1100_1110_10, 7'b0000_00_0);
    add("flt_resume", 10'b1100_1110_10, 7'b1001_00_0);

    repeat (2) @(posedge PCLK);
    #1 check("reset", 7'b0000_00_0);
    @(negedge PCLK);
    PRESET = 1'b0;

    foreach (vecs[i]) begin
      @(negedge PCLK);
      drive(vecs[i].in);
      @(posedge PCLK);
      #1 check(vecs[i].name, vecs[i].exp);
    end

    // 6: asynchronous reset while both channels sit in dead time
    @(negedge PCLK);
    drive(10'b1110_1100_10);
    @(posedge PCLK);
    #1 check("dead_both", 7'b0000_11_0);
    #2 PRESET = 1'b1;
    #1 check("preset_dead", 7'b0000_00_0);
    @(negedge PCLK);
    PRESET = 1'b0;
    drive(10'b0000_1100_10);
    @(posedge PCLK);
    #1 check("post_rst_b", 7'b0010_00_0);

    // Asynchronous reset while the fault latch is set
    @(negedge PCLK);
    FAULT_N = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 check("fault_set", 7'b0010_00_1);
    #2 PRESET = 1'b1;
    #1 check("preset_fault", 7'b0000_00_0);
    @(negedge PCLK);
    FAULT_N = 1'b1;
    PRESET  = 1'b0;
    @(posedge PCLK);
    #1 check("post_rst_b2", 7'b0010_00_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
